// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter that shares one WIDTH-bit register among N_REQ requesters.
// Optional macro DFF_ARB_PRIORITY0_EN gives requester 0 fixed top priority.
module dff_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wr_data,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       ack,
  output logic                   busy,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       q_bar,
  output logic [7:0]             wr_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t           r_state, w_state_next;
  logic [N_REQ-1:0] r_grant, w_grant_next;
  logic [N_REQ-1:0] r_ack, w_ack_next;
  logic [WIDTH-1:0] r_q, w_q_next;
  logic [7:0]       r_wr_count, w_wr_count_next;
  logic [PTR_W-1:0] r_last_ptr, w_last_ptr_next;
  logic [PTR_W-1:0] r_gnt_ptr, w_gnt_ptr_next;

  logic [WIDTH-1:0] w_slice [N_REQ];
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_gnt_req;
  logic             w_pick_valid;
  logic [PTR_W-1:0] w_pick_ptr;
  logic [N_REQ-1:0] w_pick_onehot;
  int               w_dist;
  int               w_best_dist;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign w_slice[gi] = wr_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Winner is the requester with the smallest rotational distance past last_ptr.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick_ptr   = '0;
    w_best_dist  = N_REQ;
    w_dist       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_dist = i - int'(r_last_ptr) - 1;
      if (w_dist < 0) w_dist = w_dist + N_REQ;
      if (req[i] && (w_dist < w_best_dist)) begin
        w_best_dist  = w_dist;
        w_pick_valid = 1'b1;
        w_pick_ptr   = PTR_W'(i);
      end
    end
`ifdef DFF_ARB_PRIORITY0_EN
    if (req[0]) begin
      w_pick_valid = 1'b1;
      w_pick_ptr   = '0;
    end
`endif
  end

  assign w_pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_ptr;

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) w_gnt_data = w_gnt_data | w_slice[i];
    end
  end

  assign w_gnt_req = |(req & r_grant);

  always_comb begin
    w_state_next    = r_state;
    w_grant_next    = r_grant;
    w_ack_next      = '0;
    w_q_next        = r_q;
    w_wr_count_next = r_wr_count;
    w_last_ptr_next = r_last_ptr;
    w_gnt_ptr_next  = r_gnt_ptr;
    case (r_state)
      S_IDLE: begin
        w_grant_next = '0;
        if (w_pick_valid) begin
          w_grant_next   = w_pick_onehot;
          w_gnt_ptr_next = w_pick_ptr;
          w_state_next   = S_GRANT;
        end
      end
      S_GRANT: begin
        w_grant_next = '0;
        w_state_next = S_IDLE;
        // A dropped request aborts silently; the pointer keeps its old position.
        if (w_gnt_req) begin
          w_state_next    = S_WRITE;
          w_q_next        = w_gnt_data;
          w_ack_next      = r_grant;
          w_wr_count_next = r_wr_count + 8'd1;
`ifdef DFF_ARB_PRIORITY0_EN
          if (r_gnt_ptr != '0) w_last_ptr_next = r_gnt_ptr;
`else
          w_last_ptr_next = r_gnt_ptr;
`endif
        end
      end
      S_WRITE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_ack      <= '0;
      r_q        <= '0;
      r_wr_count <= '0;
      r_last_ptr <= PTR_W'(N_REQ - 1);
      r_gnt_ptr  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_grant    <= w_grant_next;
      r_ack      <= w_ack_next;
      r_q        <= w_q_next;
      r_wr_count <= w_wr_count_next;
      r_last_ptr <= w_last_ptr_next;
      r_gnt_ptr  <= w_gnt_ptr_next;
    end
  end

  assign grant    = r_grant;
  assign ack      = r_ack;
  assign busy     = (r_state != S_IDLE);
  assign q        = r_q;
  assign q_bar    = ~r_q;
  assign wr_count = r_wr_count;

endmodule
